// File: rtl/lau_pkg.sv
// lau_pkg: shared types and helpers for the LAU sort/search datapath blocks.
//
// Contents:
//   speed_e          - implementation style selector for comparator slices
//   cmp_seq_state_e  - state encoding of the chunk-serial compare controller
//   num_chunks()     - ceil(width/chunk), the number of slices a word splits into
package lau_pkg;

    typedef enum logic {
        SLOW = 1'b0,
        FAST = 1'b1
    } speed_e;

    typedef enum logic [1:0] {
        CSC_IDLE,
        CSC_CMP,
        CSC_DONE
    } cmp_seq_state_e;

    function automatic int num_chunks(input int width, input int chunk);
        return (width + chunk - 1) / chunk;
    endfunction

endpackage

// File: rtl/cmp_seq_ctrl_cmpeqge.sv
// CmpEQGE: combinational unsigned equality / greater-or-equal comparator.
//
// Parameters:
//   width - operand width in bits
//   speed - FAST uses direct relational operators, SLOW derives both flags
//           from a single borrow-chain subtraction
// Ports:
//   a, b  in  width  operands
//   eq    out 1      a == b
//   ge    out 1      a >= b (unsigned)
module CmpEQGE
    import lau_pkg::*;
#(
    parameter int     width = 8,
    parameter speed_e speed = FAST
) (
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    output logic             eq,
    output logic             ge
);

    generate
        if (speed == FAST) begin : g_fast
            assign eq = (a == b);
            assign ge = (a >= b);
        end else begin : g_slow
            logic [width:0] diff;
            // The extra MSB of the difference is the borrow out: set iff a < b.
            assign diff = {1'b0, a} - {1'b0, b};
            assign eq   = (diff[width-1:0] == '0);
            assign ge   = ~diff[width];
        end
    endgenerate

endmodule

// File: rtl/cmp_seq_ctrl.sv
// cmp_seq_ctrl: chunk-serial wide comparator.
//
// Compares two width-bit operands by feeding one chunk-bit slice per cycle,
// MSB slice first, through a single CmpEQGE instance. The walk stops at the
// first unequal slice, so a result takes 1..NCH compare cycles.
//
// Parameters:
//   width - operand width (>= 1)
//   chunk - slice width per compare cycle (1 <= chunk <= width)
//   speed - passed to the CmpEQGE instance
// Ports:
//   CLK        in   1      clock
//   RST        in   1      synchronous active-high reset
//   IN_VALID   in   1      operands valid
//   IN_READY   out  1      operands can be accepted (combinational)
//   A, B       in   width  operands
//   SIGNED     in   1      two's-complement compare (only with CMP_SEQ_SIGNED_EN)
//   OUT_VALID  out  1      result valid
//   OUT_READY  in   1      consumer takes the result
//   EQ         out  1      A == B
//   GE         out  1      A >= B
//   CYCLES     out  $clog2(NCH+1)  compare cycles spent on the current result
//
// Build option: define CMP_SEQ_SIGNED_EN to add the SIGNED port.
module cmp_seq_ctrl
    import lau_pkg::*;
#(
    parameter int     width = 32,
    parameter int     chunk = 8,
    parameter speed_e speed = FAST
) (
    input  logic                                                  CLK,
    input  logic                                                  RST,
    input  logic                                                  IN_VALID,
    output logic                                                  IN_READY,
    input  logic [width-1:0]                                      A,
    input  logic [width-1:0]                                      B,
`ifdef CMP_SEQ_SIGNED_EN
    input  logic                                                  SIGNED,
`endif
    output logic                                                  OUT_VALID,
    input  logic                                                  OUT_READY,
    output logic                                                  EQ,
    output logic                                                  GE,
    output logic [$clog2(lau_pkg::num_chunks(width, chunk)+1)-1:0] CYCLES
);

    localparam int NCH   = num_chunks(width, chunk);
    localparam int EXT_W = NCH * chunk;
    localparam int KW    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CW    = $clog2(NCH + 1);
    localparam logic [KW-1:0] K_LAST = KW'(NCH - 1);

    cmp_seq_state_e   state;
    logic [KW-1:0]    k;
    logic             out_valid;
    logic             eq_r;
    logic             ge_r;
    logic [CW-1:0]    cycles;

    logic [EXT_W-1:0] a_r;
    logic [EXT_W-1:0] b_r;
    logic [chunk-1:0] a_ch;
    logic [chunk-1:0] b_ch;
    logic             ch_eq;
    logic             ch_ge;
    logic             sgn_in;
    logic             accept;

`ifdef CMP_SEQ_SIGNED_EN
    assign sgn_in = SIGNED;
`else
    assign sgn_in = 1'b0;
`endif

    // Zero-extend to a whole number of slices. Flipping the sign bit maps
    // two's-complement order onto unsigned order, so the slice comparator
    // stays unsigned; equality is unchanged because both operands flip.
    function automatic logic [EXT_W-1:0] extend(input logic [width-1:0] v,
                                                input logic             sgn);
        logic [EXT_W-1:0] r;
        r          = EXT_W'(v);
        r[width-1] = v[width-1] ^ sgn;
        return r;
    endfunction

    assign IN_READY = !RST && ((state == CSC_IDLE) ||
                               ((state == CSC_DONE) && OUT_READY));
    assign accept   = IN_VALID && IN_READY;

    // Operand registers hold data only; they need no reset.
    always_ff @(posedge CLK) begin
        if (accept) begin
            a_r <= extend(A, sgn_in);
            b_r <= extend(B, sgn_in);
        end
    end

    always_comb begin
        a_ch = '0;
        b_ch = '0;
        for (int i = 0; i < NCH; i++) begin
            if (k == KW'(i)) begin
                a_ch = a_r[i*chunk +: chunk];
                b_ch = b_r[i*chunk +: chunk];
            end
        end
    end

    CmpEQGE #(
        .width (chunk),
        .speed (speed)
    ) u_cmp (
        .a  (a_ch),
        .b  (b_ch),
        .eq (ch_eq),
        .ge (ch_ge)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= CSC_IDLE;
            k         <= K_LAST;
            out_valid <= 1'b0;
            eq_r      <= 1'b0;
            ge_r      <= 1'b0;
            cycles    <= '0;
        end else begin
            case (state)
                CSC_IDLE: begin
                    if (accept) begin
                        state  <= CSC_CMP;
                        k      <= K_LAST;
                        cycles <= '0;
                    end
                end
                CSC_CMP: begin
                    cycles <= cycles + CW'(1);
                    if (!ch_eq) begin
                        eq_r      <= 1'b0;
                        ge_r      <= ch_ge;
                        out_valid <= 1'b1;
                        state     <= CSC_DONE;
                    end else if (k == '0) begin
                        eq_r      <= 1'b1;
                        ge_r      <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= CSC_DONE;
                    end else begin
                        k <= k - KW'(1);
                    end
                end
                CSC_DONE: begin
                    if (OUT_READY) begin
                        out_valid <= 1'b0;
                        // New operands in the same cycle skip the idle bubble.
                        if (accept) begin
                            state  <= CSC_CMP;
                            k      <= K_LAST;
                            cycles <= '0;
                        end else begin
                            state <= CSC_IDLE;
                        end
                    end
                end
                default: begin
                    state     <= CSC_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign OUT_VALID = out_valid;
    assign EQ        = eq_r;
    assign GE        = ge_r;
    assign CYCLES    = cycles;

endmodule

// File: doc/cmp_seq_ctrl.md
Name: cmp_seq_ctrl

Overview:
- Chunk-serial controller that compares two wide operands by reusing one CmpEQGE instance of narrow width.
- Walks the chunks from MSB to LSB, one per cycle, and exits early on the first unequal chunk.
- Used where a full-width parallel comparator is too large, e.g. 64/128-bit key compare in LAU sort/search units.
- Valid/ready handshake on both sides.

Parameters:
- width, 32, operand word width in bits (>= 1)
- chunk, 8, comparator slice width per cycle (1 <= chunk <= width)
- speed, lau_pkg::FAST, speed passed through to the CmpEQGE instance

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- IN_VALID  in  1  operands valid
- IN_READY  out  1  block can accept operands
- A  in  width  operand A
- B  in  width  operand B
- OUT_VALID  out  1  result valid
- OUT_READY  in  1  consumer accepts result
- EQ  out  1  A == B
- GE  out  1  A >= B
- CYCLES  out  $clog2(NCH+1)  number of compare cycles used for the current result

Behaviour:
- Interface (decided): single clock CLK; RST is synchronous and active-high.
- NCH = ceil(width/chunk). Operands are zero-extended at the MSB end to NCH*chunk bits.
- States: IDLE, CMP, DONE.
- Reset values: state=IDLE, chunk index k=NCH-1, OUT_VALID=0, EQ=0, GE=0, CYCLES=0. IN_READY is 0 while RST=1.
- IN_READY = (state==IDLE) | (state==DONE & OUT_READY). It is combinational from state and OUT_READY.
- IDLE: on IN_VALID & IN_READY, register A and B, set k=NCH-1, go to CMP.
- CMP: each cycle, CmpEQGE compares chunk k of the registered A and B. CYCLES increments.
  - Chunk not equal: latch EQ=0 and GE=chunk GE, go to DONE.
  - Chunk equal and k==0: latch EQ=1 and GE=1, go to DONE.
  - Otherwise: k=k-1 and stay in CMP.
- DONE: OUT_VALID=1. EQ, GE and CYCLES stay stable until OUT_VALID & OUT_READY.
  - On handshake with IN_VALID also high: capture the new operands and go to CMP (back-to-back; no idle bubble).
  - On handshake without IN_VALID: go to IDLE with OUT_VALID=0.
- Latency: accept-to-OUT_VALID is 1..NCH cycles of CMP. OUT_VALID rises the cycle after the deciding chunk.
- Throughput: one result per (cycles+1) without bubble in steady state.
- Outputs EQ, GE and CYCLES are registered and keep their last value when OUT_VALID=0. CYCLES clears when new operands are accepted.
- NCH==1: CMP always lasts exactly 1 cycle.
- RST in any state: next cycle IDLE, OUT_VALID=0, the in-flight operation is discarded, and outputs return to their reset values.
- Input changes while IN_READY=0 are ignored.
- OUT_READY high while OUT_VALID=0 has no effect.

Optional Feature:
- Macro: CMP_SEQ_SIGNED_EN.
- Defined: adds port SIGNED (in, 1), sampled with the operands.
  - When SIGNED=1, bit width-1 of both registered operands is inverted before chunking. This gives two's-complement GE; EQ is unaffected.
  - SIGNED is held with the operands for the whole operation.
- Undefined: no SIGNED port; compare is unsigned only.

Decomposition:
- lau_pkg gets:
  - typedef enum logic [1:0] {CSC_IDLE, CSC_CMP, CSC_DONE} cmp_seq_state_e;
  - function num_chunks(width, chunk) returning ceil(width/chunk).
- Sub-module: the existing CmpEQGE #(chunk, speed), one instance, fed by a chunk mux on k. No new sub-module is needed.

Test Plan (width=32, chunk=8, NCH=4):
- A=B=0x12345678 -> 4 CMP cycles; EQ=1, GE=1, CYCLES=4.
- A=0x80000000, B=0x7FFFFFFF -> early exit; EQ=0, GE=1, CYCLES=1, OUT_VALID 2 cycles after accept.
- A=0x12345677, B=0x12345678 -> EQ=0, GE=0, CYCLES=4.
- Backpressure: OUT_READY=0 for 5 cycles after OUT_VALID -> EQ, GE and CYCLES stable, IN_READY=0. Then OUT_READY=1 with IN_VALID=1 (A=1, B=2) -> same-cycle accept, next result EQ=0, GE=0, CYCLES=4.
- RST=1 during CMP at k=2 -> next cycle IDLE, OUT_VALID=0, EQ=0, GE=0, IN_READY=1 once RST=0. A following A=B=0 compare gives EQ=1.
- With CMP_SEQ_SIGNED_EN, A=0xFFFFFFFF, B=0x00000001:
  - SIGNED=1 -> GE=0, EQ=0, CYCLES=1.
  - SIGNED=0 -> GE=1, EQ=0, CYCLES=1.
